// File: rtl/csa_resolve_pipe.sv
// Resolves a carry-save (sum, carry, cin) triple via a pipelined Kogge-Stone prefix tree; latency LEVELS+2.
// Whole pipe stalls when out_valid & !out_ready (in_ready = !out_valid | out_ready); optional out_ovf under CSA_RESOLVE_OVF_EN.
module csa_resolve_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_cin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_cout,
`ifdef CSA_RESOLVE_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = $clog2(WIDTH);

  logic             advance;
  logic [WIDTH-1:0] g_n  [0:LEVELS];
  logic [WIDTH-1:0] g_q  [0:LEVELS];
  logic [WIDTH-1:0] p_n  [0:LEVELS-1];
  logic [WIDTH-1:0] p_q  [0:LEVELS-1];
  logic [WIDTH-1:0] pb_q [0:LEVELS];
  logic [LEVELS:0]  cin_q;
  logic [LEVELS:0]  vld_q;
  logic [WIDTH-1:0] carry_vec;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Level 0 folds cin into bit 0 generate; level k merges with span 2^(k-1).
  always_comb begin
    for (int k = 0; k <= LEVELS; k++) g_n[k] = '0;
    for (int k = 0; k < LEVELS; k++)  p_n[k] = '0;
    g_n[0]    = in_sum & in_carry;
    g_n[0][0] = (in_sum[0] & in_carry[0]) | ((in_sum[0] ^ in_carry[0]) & in_cin);
    p_n[0]    = in_sum ^ in_carry;
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1)))
          g_n[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][i - (1 << (k - 1))]);
        else
          g_n[k][i] = g_q[k-1][i];
      end
    end
    for (int k = 1; k < LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << (k - 1)))
          p_n[k][i] = p_q[k-1][i] & p_q[k-1][i - (1 << (k - 1))];
        else
          p_n[k][i] = p_q[k-1][i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      for (int k = 0; k <= LEVELS; k++) g_q[k] <= g_n[k];
      for (int k = 0; k < LEVELS; k++)  p_q[k] <= p_n[k];
      pb_q[0]  <= p_n[0];
      for (int k = 1; k <= LEVELS; k++) pb_q[k] <= pb_q[k-1];
      cin_q    <= {cin_q[LEVELS-1:0], in_cin};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      vld_q <= '0;
    else if (advance)
      vld_q <= {vld_q[LEVELS-1:0], in_valid};
  end

  // Carry into bit i is the full-prefix generate of bit i-1; cin enters bit 0.
  assign carry_vec = {g_q[LEVELS][WIDTH-2:0], cin_q[LEVELS]};

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_cout   <= 1'b0;
`ifdef CSA_RESOLVE_OVF_EN
      out_ovf    <= 1'b0;
`endif
    end else if (advance) begin
      out_valid <= vld_q[LEVELS];
      if (vld_q[LEVELS]) begin
        out_result <= pb_q[LEVELS] ^ carry_vec;
        out_cout   <= g_q[LEVELS][WIDTH-1];
`ifdef CSA_RESOLVE_OVF_EN
        out_ovf    <= g_q[LEVELS][WIDTH-1] ^ g_q[LEVELS][WIDTH-2];
`endif
      end
    end
  end

endmodule

// File: tb/tb_csa_resolve_pipe.sv
// Scoreboard bench for csa_resolve_pipe at WIDTH=8: latency, wrap, streaming, stall and reset flush.
module tb_csa_resolve_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_sum, in_carry;
  logic         in_cin, in_valid, in_ready;
  logic [W-1:0] out_result;
  logic         out_cout, out_valid, out_ready;
`ifdef CSA_RESOLVE_OVF_EN
  logic         out_ovf;
`endif

  always #5 clk = ~clk;

  csa_resolve_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_sum(in_sum), .in_carry(in_carry), .in_cin(in_cin),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_result(out_result), .out_cout(out_cout),
`ifdef CSA_RESOLVE_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    logic [W:0] full;
    exp_t r;
    full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    r.res  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return r;
  endfunction

  // Output monitor: every retiring beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat result=%h cout=%b (scoreboard empty)", out_result, out_cout);
      end else begin
        mon_e = sb.pop_front();
        checks++;
        if (out_result !== mon_e.res) begin
          errors++; $display("FAIL result got=%h exp=%h", out_result, mon_e.res);
        end
        checks++;
        if (out_cout !== mon_e.cout) begin
          errors++; $display("FAIL cout got=%b exp=%b (result %h)", out_cout, mon_e.cout, mon_e.res);
        end
`ifdef CSA_RESOLVE_OVF_EN
        checks++;
        if (out_ovf !== mon_e.ovf) begin
          errors++; $display("FAIL ovf got=%b exp=%b (result %h)", out_ovf, mon_e.ovf, mon_e.res);
        end
`endif
      end
    end
  end

  // Drives one beat; call just after a rising edge, returns just after its acceptance edge.
  task automatic send_beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    bit acc;
    acc = 0;
    in_sum = a; in_carry = b; in_cin = c; in_valid = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(model(a, b, c));
        acc = 1;
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready never asserted");
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain outstanding=%0d exp=0", sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_carry = '0; in_cin = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL reset_result got=%h exp=00", out_result); end
    checks++; if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", out_cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
`ifdef CSA_RESOLVE_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", out_ovf); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    send_beat(8'h0F, 8'h01, 1'b0);
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (c == 5)) begin
        errors++; $display("FAIL latency cycle=%0d out_valid got=%b exp=%b", c, out_valid, (c == 5));
      end
      @(posedge clk); #1;
    end
    drain();
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    send_beat(8'hFF, 8'h00, 1'b1);
    send_beat(8'h7F, 8'h01, 1'b0);
    send_beat(8'h80, 8'h80, 1'b0);
    send_beat(8'hFF, 8'hFF, 1'b1);
    in_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int run;
    out_ready = 1'b1;
    run = 0;
    fork
      begin
        for (int n = 0; n < 20; n++)
          send_beat(W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 50 && run == 0; n++) begin
          @(negedge clk);
          if (out_valid) run = 1;
        end
        for (int n = 0; n < 19; n++) begin
          @(negedge clk);
          if (out_valid) run++;
        end
      end
    join
    checks++;
    if (run != 20) begin errors++; $display("FAIL stream_rate consecutive=%0d exp=20", run); end
    drain();
  endtask

  task automatic test_stall();
    logic [W-1:0] held_r;
    logic         held_c;
    bit           seen;
    out_ready = 1'b1;
    seen = 0;
    fork
      begin
        for (int n = 0; n < 8; n++)
          send_beat(W'($urandom), W'($urandom), 1'($urandom));
        in_valid = 1'b0;
      end
      begin
        for (int n = 0; n < 50 && !seen; n++) begin
          @(negedge clk);
          if (out_valid) seen = 1;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        held_r = out_result; held_c = out_cout;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, in_ready); end
          checks++;
          if (out_valid !== 1'b1 || out_result !== held_r || out_cout !== held_c) begin
            errors++;
            $display("FAIL stall_hold cycle=%0d got=%b/%h/%b exp=1/%h/%b", c, out_valid, out_result, out_cout, held_r, held_c);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic test_reset_flush();
    bit leaked;
    out_ready = 1'b1;
    leaked = 0;
    send_beat(8'h12, 8'h34, 1'b0);
    send_beat(8'hAB, 8'hCD, 1'b1);
    send_beat(8'h55, 8'hAA, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_result !== '0) begin errors++; $display("FAIL flush_result got=%h exp=00", out_result); end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) leaked = 1;
    end
    checks++;
    if (leaked) begin errors++; $display("FAIL flush_leak got=1 exp=0"); end
    @(posedge clk); #1;
    send_beat(8'h01, 8'h02, 1'b1);
    in_valid = 1'b0;
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/csa_resolve_pipe.md
Name: csa_resolve_pipe

Overview:
- Consumes the redundant (sum, carry) vector pair produced by the carry-save datapath and resolves it to a single binary result plus carry-out.
- Uses a pipelined Kogge-Stone parallel-prefix tree built from black-cell group generate/propagate merges, with one register stage per prefix level.
- Sits at the output end of the CSA accumulator, feeding the LCG state register and downstream consumers through a valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; power of two, 4..64.
- LEVELS, clog2(WIDTH), number of prefix levels; derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_sum  input  WIDTH  CSA sum vector; bit i has weight 2^i.
- in_carry  input  WIDTH  CSA carry vector, already shifted; bit i has weight 2^i.
- in_cin  input  1  carry-in at bit 0.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- out_result  output  WIDTH  (in_sum + in_carry + in_cin) mod 2^WIDTH.
- out_cout  output  1  carry out of bit WIDTH-1.
- out_valid  output  1  output beat valid.
- out_ready  input  1  consumer accepts the output beat.

Behaviour:
- Reset, synchronous and active-high: every stage valid bit cleared; out_result=0, out_cout=0, out_valid=0. in_ready=1 in the first cycle after reset.
- Reset asserted mid-operation discards all in-flight beats; no partial beat emerges afterwards.
- Pipeline stages:
  - S0: registers bitwise g=sum&carry, p=sum^carry, with cin folded in as group generate at position -1 (bit 0 g0' = g0 | p0&cin).
  - S1..S_LEVELS: prefix level k, span 2^(k-1). Merge per bit i >= span: G = Gi | Pi&G(i-span), P = Pi&P(i-span). Bits below span pass through.
  - Final stage: result bit i = p_i ^ C(i-1), where C(-1)=cin. cout = G(WIDTH-1) of the full prefix.
- Latency: LEVELS+2 cycles from accepted input to out_valid; 7 cycles for WIDTH=32.
- Throughput: one beat per cycle when out_ready is held high.
- Handshake:
  - advance = !out_valid | out_ready, and in_ready = advance.
  - A beat is accepted when in_valid & in_ready.
  - When advance=0 every stage holds, including bubbles, and the output stays stable.
  - out_result/out_cout must not change while out_valid=1 and out_ready=0.
- Bubbles: a stage whose valid bit is 0 carries don't-care data; only valid bits propagate meaningfully.
- Simultaneous out_ready=1 with a new input: the output beat retires and the new beat enters S0 in the same cycle.
- Wrap-around: results are modulo 2^WIDTH; overflow is reported only through out_cout.
- No combinational path from in_valid to out_valid. The only combinational path is out_ready -> in_ready.

Optional Feature:
- Macro: CSA_RESOLVE_OVF_EN.
- Defined:
  - Adds output port out_ovf (1 bit), the two's-complement signed overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - out_ovf is registered and aligned with out_result, resets to 0, and holds under stall.
- Undefined: port absent, no extra logic, behaviour otherwise identical.

Test Plan:
- WIDTH=8, reset, then sum=0x0F, carry=0x01, cin=0, out_ready=1 -> after 5 cycles out_valid=1, out_result=0x10, out_cout=0.
- WIDTH=8, sum=0xFF, carry=0x00, cin=1 -> out_result=0x00, out_cout=1; with CSA_RESOLVE_OVF_EN, out_ovf=0.
- WIDTH=8, sum=0x7F, carry=0x01, cin=0 with CSA_RESOLVE_OVF_EN -> out_result=0x80, out_cout=0, out_ovf=1.
- Back-to-back stream of 20 random beats with out_ready=1 -> one result per cycle, in order, all matching the reference sum.
- Stall: out_ready=0 for 4 cycles while out_valid=1 -> in_ready=0, out_result stable, no beats lost or duplicated after release.
- rst pulsed with 3 beats in flight -> next cycle out_valid=0, out_result=0, and none of those 3 beats ever appears at the output.
